rvga_console_uart_tx: RTL

- Memory-mapped console responder at the byte-write console port (base 0x1000_0000).
- Accepts CPU byte writes with backpressure and buffers them in a small FIFO.
- Serializes each byte as an 8N1 UART frame on tx_o.
- Exposes a readable line-status register so firmware can poll before writing, instead of relying on backpressure.

---
 rtl/rvga_console_pkg.sv | 19 +
 rtl/rvga_fifo.sv | 50 +++++
 rtl/rvga_console_uart_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rvga_console_pkg.sv
// Shared constants and types for the console UART transmitter.
// Holds the MMIO address map, the line-status bit positions and the TX FSM state encoding.
package rvga_console_pkg;

  localparam logic [31:0] rvga_console_thr_addr_gp = 32'h1000_0000;
  localparam logic [31:0] rvga_console_lsr_off_gp  = 32'd5;

  localparam int rvga_console_lsr_nonempty_bit_gp = 0;
  localparam int rvga_console_lsr_not_full_bit_gp = 5;
  localparam int rvga_console_lsr_tx_idle_bit_gp  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rvga_uart_tx_state_e;

endpackage

// File: rtl/rvga_fifo.sv
// Small synchronous FIFO with registered status flags.
// The pointers carry one extra wrap bit, so full and empty are told apart without a counter.
module rvga_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int addr_w_lp = $clog2(els_p);
  localparam logic [addr_w_lp:0] ptr_one_lp = {{addr_w_lp{1'b0}}, 1'b1};

  logic [addr_w_lp:0] wptr_r;
  logic [addr_w_lp:0] rptr_r;
  logic [width_p-1:0] mem_r [els_p];
  logic               do_push;
  logic               do_pop;

  assign full_o  = (wptr_r[addr_w_lp] != rptr_r[addr_w_lp]) &&
                   (wptr_r[addr_w_lp-1:0] == rptr_r[addr_w_lp-1:0]);
  assign empty_o = (wptr_r == rptr_r);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push) wptr_r <= wptr_r + ptr_one_lp;
      if (do_pop)  rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_r[wptr_r[addr_w_lp-1:0]] <= data_i;
  end

  assign data_o = mem_r[rptr_r[addr_w_lp-1:0]];

endmodule

// File: rtl/rvga_console_uart_tx.sv
// Memory-mapped console: byte writes to THR are queued and sent as 8N1 frames on tx_o.
// LSR at THR+5 lets firmware poll for space and idleness instead of stalling on w_ready_o.
module rvga_console_uart_tx
  import rvga_console_pkg::*;
#(
  parameter logic [31:0] base_addr_p    = rvga_console_thr_addr_gp,
  parameter int          fifo_els_p     = 8,
  parameter int          clks_per_bit_p = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        w_v_i,
  output logic        w_ready_o,
  input  logic        r_v_i,
  output logic        r_v_o,
  output logic [7:0]  r_data_o,
  output logic        tx_o
);

  localparam int                  cyc_w_lp    = $clog2(clks_per_bit_p);
  localparam logic [cyc_w_lp-1:0] last_cyc_lp = cyc_w_lp'(clks_per_bit_p - 1);
  localparam logic [cyc_w_lp-1:0] cyc_one_lp  = cyc_w_lp'(1);
  localparam logic [31:0]         lsr_addr_lp = base_addr_p + rvga_console_lsr_off_gp;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_data;

  rvga_uart_tx_state_e state_r, state_n;
  logic [cyc_w_lp-1:0] cyc_r, cyc_n;
  logic [2:0]          bit_r, bit_n;
  logic [7:0]          shift_r, shift_n;
  logic [7:0]          lsr;
  logic                tx_idle;

  rvga_fifo #(
    .width_p (8),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .data_i    (data_i),
    .pop_i     (fifo_pop),
    .data_o    (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Ready comes purely from registered FIFO state so it never combinationally loops back to the master.
  assign w_ready_o = ~fifo_full;
  assign fifo_push = w_v_i & ~fifo_full & (addr_i == base_addr_p);

  assign tx_idle = (state_r == IDLE) & fifo_empty;

  always_comb begin
    lsr = 8'h00;
    lsr[rvga_console_lsr_nonempty_bit_gp] = ~fifo_empty;
    lsr[rvga_console_lsr_not_full_bit_gp] = ~fifo_full;
    lsr[rvga_console_lsr_tx_idle_bit_gp]  = tx_idle;
  end

  // Reads are never blocked; the response reflects state before any push in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_o    <= 1'b0;
      r_data_o <= 8'h00;
    end else begin
      r_v_o <= r_v_i;
      if (r_v_i) r_data_o <= (addr_i == lsr_addr_lp) ? lsr : 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cyc_r   <= '0;
      bit_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_n;
      cyc_r   <= cyc_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // tx_o is decoded from registered state, so an asynchronous reset forces the line high at once.
  always_comb begin
    state_n  = state_r;
    cyc_n    = cyc_r;
    bit_n    = bit_r;
    shift_n  = shift_r;
    fifo_pop = 1'b0;
    tx_o     = 1'b1;
    unique case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_data;
          state_n  = START;
          cyc_n    = '0;
          bit_n    = '0;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (cyc_r == last_cyc_lp) begin
          state_n = DATA;
          cyc_n   = '0;
          bit_n   = '0;
        end else begin
          cyc_n = cyc_r + cyc_one_lp;
        end
      end
      DATA: begin
        tx_o = shift_r[0];
        if (cyc_r == last_cyc_lp) begin
          cyc_n   = '0;
          shift_n = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          cyc_n = cyc_r + cyc_one_lp;
        end
      end
      STOP: begin
        if (cyc_r == last_cyc_lp) begin
          state_n = IDLE;
          cyc_n   = '0;
          bit_n   = '0;
        end else begin
          cyc_n = cyc_r + cyc_one_lp;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
